// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction memory boot loader:
// FSM state encodings and the memory depth derivation.
package inst_mem_loader_pkg;

    typedef enum logic [2:0] {
        LDR_IDLE   = 3'd0,
        LDR_HEADER = 3'd1,
        LDR_DATA   = 3'd2,
        LDR_CHECK  = 3'd3,
        LDR_DONE   = 3'd4,
        LDR_ERROR  = 3'd5
    } ldr_state_t;

    localparam int BYTES_PER_WORD = 4;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Assembles four stream bytes into a 32-bit word in the selected byte order.
// word_out is the word including the byte currently offered on byte_in.
module byte_word_packer #(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  byte_in,
    input  logic        byte_en,
    input  logic        clear,
    output logic [31:0] word_out,
    output logic        word_full
);

    logic [1:0]  idx;
    logic [31:0] word_q;

    // Big-endian shifts older bytes up so the first byte lands in [31:24];
    // little-endian shifts them down so the first byte lands in [7:0].
    always_comb begin
        if (BIG_ENDIAN) word_out = {word_q[23:0], byte_in};
        else            word_out = {byte_in, word_q[31:8]};
    end

    assign word_full = byte_en && (idx == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= 2'd0;
            word_q <= 32'd0;
        end else if (clear) begin
            idx    <= 2'd0;
            word_q <= 32'd0;
        end else if (byte_en) begin
            idx    <= idx + 2'd1;
            word_q <= word_out;
        end
    end

endmodule

// File: rtl/inst_mem_loader.sv
// Boot loader: receives header/payload/checksum bytes, writes instruction
// memory one word at a time and releases the core only after a good image.
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int ADDR_W     = 6,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_wa,
    output logic [31:0]       imem_wd,
    output logic              cpu_rst,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int DEPTH = depth_of(ADDR_W);
    localparam logic [ADDR_W:0] ONE = 1;

    ldr_state_t      state;
    logic [ADDR_W:0] n_words;
    logic [7:0]      csum;
    logic [ADDR_W:0] wl_next;
    logic            xfer;
    logic            bad_hdr;
    logic            pk_clear;
    logic [31:0]     word_out;
    logic            word_full;

    assign xfer     = in_valid && in_ready;
    assign wl_next  = words_loaded + ONE;
    assign bad_hdr  = (in_data == 8'd0) || (int'(in_data) > DEPTH);
    assign pk_clear = start && (state == LDR_IDLE || state == LDR_DONE || state == LDR_ERROR);

    byte_word_packer #(.BIG_ENDIAN(BIG_ENDIAN)) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .byte_in   (in_data),
        .byte_en   (xfer && (state == LDR_DATA)),
        .clear     (pk_clear),
        .word_out  (word_out),
        .word_full (word_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= LDR_IDLE;
            cpu_rst      <= 1'b1;
            in_ready     <= 1'b0;
            imem_we      <= 1'b0;
            imem_wa      <= '0;
            imem_wd      <= 32'd0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            n_words      <= '0;
            csum         <= 8'd0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                LDR_IDLE, LDR_DONE, LDR_ERROR: begin
                    if (start) begin
                        state        <= LDR_HEADER;
                        in_ready     <= 1'b1;
                        cpu_rst      <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= '0;
                        csum         <= 8'd0;
                    end
                end
                LDR_HEADER: begin
                    if (xfer) begin
                        csum    <= csum ^ in_data;
                        n_words <= (ADDR_W+1)'(in_data);
                        if (bad_hdr) begin
                            state    <= LDR_ERROR;
                            in_ready <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            state <= LDR_DATA;
                        end
                    end
                end
                LDR_DATA: begin
                    if (xfer) begin
                        csum <= csum ^ in_data;
                        // Word index equals the count of words already written.
                        if (word_full) begin
                            imem_we      <= 1'b1;
                            imem_wa      <= words_loaded[ADDR_W-1:0];
                            imem_wd      <= word_out;
                            words_loaded <= wl_next;
                            if (wl_next == n_words) state <= LDR_CHECK;
                        end
                    end
                end
                LDR_CHECK: begin
                    if (xfer) begin
                        in_ready <= 1'b0;
                        if (in_data == csum) begin
                            state   <= LDR_DONE;
                            done    <= 1'b1;
                            cpu_rst <= 1'b0;
                        end else begin
                            state <= LDR_ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= LDR_IDLE;
                    in_ready <= 1'b0;
                    cpu_rst  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: normal, bad checksum, bad header,
// backpressure, full image and mid-load reset.
module tb_inst_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [5:0]  imem_wa;
    logic [31:0] imem_wd;
    logic        cpu_rst;
    logic        done;
    logic        error;
    logic [6:0]  words_loaded;

    int nchk = 0;
    int nerr = 0;

    logic [5:0]  wa_q[$];
    logic [31:0] wd_q[$];
    logic [7:0]  stim[$];
    logic [31:0] exp_w[64];

    inst_mem_loader #(.ADDR_W(6), .BIG_ENDIAN(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_wa      (imem_wa),
        .imem_wd      (imem_wd),
        .cpu_rst      (cpu_rst),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Write monitor samples on the falling edge, mid-cycle.
    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            wa_q.push_back(imem_wa);
            wd_q.push_back(imem_wd);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic send_stream(input int maxgap);
        foreach (stim[i]) send(stim[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_two(input logic [7:0] last, input int maxgap);
        wa_q.delete();
        wd_q.delete();
        do_start();
        stim = '{8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04, last};
        send_stream(maxgap);
    endtask

    task automatic check_two_writes(input string tag);
        chk({tag, "_nwr"}, wa_q.size(), 2);
        if (wa_q.size() == 2) begin
            chk({tag, "_wa0"}, wa_q[0], 0);
            chk({tag, "_wd0"}, wd_q[0], 32'h20080005);
            chk({tag, "_wa1"}, wa_q[1], 1);
            chk({tag, "_wd1"}, wd_q[1], 32'h8C090004);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_cpu_rst"}, cpu_rst, 1);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_we"}, imem_we, 0);
        chk({tag, "_wa"}, imem_wa, 0);
        chk({tag, "_wd"}, imem_wd, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_wl"}, words_loaded, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cs;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outs("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Normal 2-word load
        load_two(8'hAE, 0);
        check_two_writes("norm");
        chk("norm_done", done, 1);
        chk("norm_cpu_rst", cpu_rst, 0);
        chk("norm_wl", words_loaded, 2);
        chk("norm_err", error, 0);
        chk("norm_rdy", in_ready, 0);

        // Bad checksum, then recovery
        load_two(8'hAF, 0);
        check_two_writes("badcs");
        chk("badcs_err", error, 1);
        chk("badcs_done", done, 0);
        chk("badcs_cpu_rst", cpu_rst, 1);
        load_two(8'hAE, 0);
        chk("recov_done", done, 1);
        chk("recov_err", error, 0);

        // Bad headers: 65 and 0
        wa_q.delete(); wd_q.delete();
        do_start();
        chk("restart_cpu_rst", cpu_rst, 1);
        chk("restart_done", done, 0);
        send(8'h41, 0);
        chk("hdr41_err", error, 1);
        chk("hdr41_rdy", in_ready, 0);
        repeat (3) @(negedge clk);
        chk("hdr41_nwr", wa_q.size(), 0);
        do_start();
        chk("hdr00_errclr", error, 0);
        send(8'h00, 0);
        chk("hdr00_err", error, 1);
        repeat (3) @(negedge clk);
        chk("hdr00_nwr", wa_q.size(), 0);
        chk("hdr00_cpu_rst", cpu_rst, 1);

        // Backpressure with random gaps and garbage data
        load_two(8'hAE, 5);
        check_two_writes("bp");
        chk("bp_done", done, 1);
        chk("bp_wl", words_loaded, 2);

        // Full 64-word image with a stray start mid-DATA
        cs = 8'h40;
        stim = '{8'h40};
        for (int i = 0; i < 64; i++) begin
            exp_w[i] = {8'(i), ~8'(i), 8'hA5 ^ 8'(i), 8'h3C};
            for (int b = 3; b >= 0; b--) begin
                stim.push_back(exp_w[i][b*8 +: 8]);
                cs ^= exp_w[i][b*8 +: 8];
            end
        end
        stim.push_back(cs);
        wa_q.delete(); wd_q.delete();
        do_start();
        foreach (stim[k]) begin
            if (k == 100) start = 1'b1;
            send(stim[k], 0);
            start = 1'b0;
        end
        chk("full_done", done, 1);
        chk("full_wl", words_loaded, 64);
        chk("full_nwr", wa_q.size(), 64);
        if (wa_q.size() == 64) begin
            for (int i = 0; i < 64; i++) begin
                chk($sformatf("full_wa%0d", i), wa_q[i], 32'(i));
                chk($sformatf("full_wd%0d", i), wd_q[i], exp_w[i]);
            end
        end

        // Reset mid-load after 6 accepted bytes
        wa_q.delete(); wd_q.delete();
        do_start();
        stim = '{8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C};
        send_stream(0);
        chk("mid_wl_pre", words_loaded, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load_two(8'hAE, 0);
        check_two_writes("post");
        chk("post_done", done, 1);

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
